// File: rtl/eth_pkg.sv
// eth_pkg: shared types and constants for the Ethernet TX scheduler
package eth_pkg;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        ARP_REQ  = 2'd1,
        ARP_RESP = 2'd2,
        UDP      = 2'd3
    } pkt_type_t;

    typedef enum logic {
        TX_ARP = 1'b0,
        TX_UDP = 1'b1
    } tx_kind_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        IFG   = 2'd3
    } sched_state_t;

    localparam logic [10:0] ARP_FRAME_LEN = 11'd28;

    // An ARP request asks for our reply only when its target IP is ours
    function automatic logic arp_hit(
        input logic [1:0]  pkt_type,
        input logic [31:0] tpa,
        input logic [31:0] self_ip
    );
        return (pkt_type_t'(pkt_type) == ARP_REQ) && (tpa == self_ip);
    endfunction

endpackage

// File: rtl/eth_arp_slot.sv
// eth_arp_slot: one-entry holder for the pending ARP reply (requester MAC/IP)
module eth_arp_slot
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  i_rx_pkt_type,
    input  logic [31:0] i_rx_tpa,
    input  logic [31:0] i_self_ip,
    input  logic [47:0] i_rx_sha,
    input  logic [31:0] i_rx_spa,
    input  logic        i_consume,
    output logic        o_valid,
    output logic [47:0] o_sha,
    output logic [31:0] o_spa,
    output logic        o_drop
);

    logic load;

    assign load = arp_hit(i_rx_pkt_type, i_rx_tpa, i_self_ip);

    // A new request always lands in the slot; consume only empties it when nothing arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_sha   <= '0;
            o_spa   <= '0;
        end else if (load) begin
            o_valid <= 1'b1;
            o_sha   <= i_rx_sha;
            o_spa   <= i_rx_spa;
        end else if (i_consume) begin
            o_valid <= 1'b0;
        end
    end

    // Overwriting a reply that is not being granted this cycle loses it
    always_comb begin
        o_drop = load && o_valid && !i_consume;
    end

endmodule

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: ARP-first TX framer arbiter with streak limit, timeout and IFG (stats: ETH_TX_STATS_EN)
module eth_tx_sched
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES     = 12,
    parameter int TX_TIMEOUT     = 2048,
    parameter int MAX_ARP_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] i_self_mac,
    input  logic [31:0] i_self_ip,
    input  logic [1:0]  i_rx_pkt_type,
    input  logic [47:0] i_rx_sha,
    input  logic [31:0] i_rx_spa,
    input  logic [31:0] i_rx_tpa,
    input  logic        i_udp_req,
    input  logic [47:0] i_udp_dst_mac,
    input  logic [31:0] i_udp_dst_ip,
    input  logic [10:0] i_udp_len,
    output logic        o_udp_gnt,
    output logic        o_tx_start,
    output logic        o_tx_kind,
    output logic [47:0] o_tx_dst_mac,
    output logic [31:0] o_tx_dst_ip,
    output logic [10:0] o_tx_len,
    input  logic        i_tx_done,
    output logic        o_busy,
    output logic        o_arp_drop,
`ifdef ETH_TX_STATS_EN
    output logic [15:0] o_arp_cnt,
    output logic [15:0] o_udp_cnt,
    output logic [7:0]  o_to_cnt,
`endif
    output logic        o_timeout
);

    localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int SW = $clog2(MAX_ARP_STREAK + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TX_TIMEOUT - 1);
    localparam logic [IW-1:0] IFG_LAST   = IW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_ARP_STREAK);

    sched_state_t  state, state_d;
    tx_kind_t      kind;
    logic [TW-1:0] timer;
    logic [IW-1:0] ifg_cnt;
    logic [SW-1:0] arp_streak;
    logic          slot_valid;
    logic [47:0]   slot_sha;
    logic [31:0]   slot_spa;
    logic          arp_cand, udp_cand, pick;
    logic          arp_grant, udp_grant;
    logic          timer_last, ifg_last;
    logic          unused_self_mac;

    // The framer takes its source MAC straight from the shared self address
    assign unused_self_mac = ^i_self_mac;

    eth_arp_slot u_slot (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rx_pkt_type (i_rx_pkt_type),
        .i_rx_tpa      (i_rx_tpa),
        .i_self_ip     (i_self_ip),
        .i_rx_sha      (i_rx_sha),
        .i_rx_spa      (i_rx_spa),
        .i_consume     (arp_grant),
        .o_valid       (slot_valid),
        .o_sha         (slot_sha),
        .o_spa         (slot_spa),
        .o_drop        (o_arp_drop)
    );

    // ARP wins unless UDP has already been starved for MAX_ARP_STREAK grants
    assign arp_cand   = slot_valid && (!i_udp_req || arp_streak < STREAK_MAX);
    assign udp_cand   = !arp_cand && i_udp_req;
    assign pick       = (state == IDLE) && (arp_cand || udp_cand);
    assign arp_grant  = (state == GRANT) && (kind == TX_ARP);
    assign udp_grant  = (state == GRANT) && (kind == TX_UDP);
    assign timer_last = timer == TIMER_LAST;
    assign ifg_last   = ifg_cnt == IFG_LAST;
    assign o_tx_kind  = kind;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Next-state logic; done beats a timeout landing in the same cycle
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = pick ? GRANT : IDLE;
            GRANT:   state_d = BUSY;
            BUSY:    state_d = (i_tx_done || timer_last) ? ((IFG_CYCLES == 0) ? IDLE : IFG) : BUSY;
            IFG:     state_d = ifg_last ? IDLE : IFG;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        o_tx_start = state == GRANT;
        o_udp_gnt  = udp_grant;
        o_busy     = state != IDLE;
        o_timeout  = (state == BUSY) && !i_tx_done && timer_last;
    end

    // BUSY watchdog and IFG counter both restart from zero on every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer   <= '0;
            ifg_cnt <= '0;
        end else begin
            timer   <= (state == BUSY) ? timer + TW'(1) : '0;
            ifg_cnt <= (state == IFG) ? ifg_cnt + IW'(1) : '0;
        end
    end

    // Frame descriptor is captured at the pick and held for the whole frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind         <= TX_ARP;
            o_tx_dst_mac <= '0;
            o_tx_dst_ip  <= '0;
            o_tx_len     <= '0;
        end else if (pick) begin
            kind         <= arp_cand ? TX_ARP : TX_UDP;
            o_tx_dst_mac <= arp_cand ? slot_sha : i_udp_dst_mac;
            o_tx_dst_ip  <= arp_cand ? slot_spa : i_udp_dst_ip;
            o_tx_len     <= arp_cand ? ARP_FRAME_LEN : i_udp_len;
        end
    end

    // Consecutive ARP grants, saturating; any UDP grant resets the streak
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            arp_streak <= '0;
        else
            arp_streak <= udp_grant ? '0 :
                          (arp_grant && arp_streak != STREAK_MAX) ? arp_streak + SW'(1) : arp_streak;
    end

`ifdef ETH_TX_STATS_EN
    // Grant counters wrap; the timeout counter sticks at its maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_arp_cnt <= '0;
            o_udp_cnt <= '0;
            o_to_cnt  <= '0;
        end else begin
            o_arp_cnt <= o_arp_cnt + 16'(arp_grant);
            o_udp_cnt <= o_udp_cnt + 16'(udp_grant);
            o_to_cnt  <= (o_timeout && o_to_cnt != 8'hFF) ? o_to_cnt + 8'd1 : o_to_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: directed vector table plus multi-cycle sequences for eth_tx_sched
module tb_eth_tx_sched;
    import eth_pkg::*;

    localparam logic [31:0] SELF_IP  = 32'hC0A8_0002;
    localparam logic [47:0] SELF_MAC = 48'h0200_0000_0002;
    localparam logic [31:0] UDP_IP   = 32'hC0A8_0063;
    localparam logic [47:0] UDP_MAC  = 48'h0200_0000_0063;
    localparam logic [10:0] UDP_LEN  = 11'd100;
    localparam logic [31:0] IP_A = 32'h0A00_000A, IP_B = 32'h0A00_000B, IP_C = 32'h0A00_000C;
    localparam logic [31:0] IP_D = 32'h0A00_000D, IP_E = 32'h0A00_000E;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  i_rx_pkt_type = '0;
    logic [47:0] i_rx_sha = '0;
    logic [31:0] i_rx_spa = '0, i_rx_tpa = '0;
    logic        i_udp_req = 1'b0, i_tx_done = 1'b0;
    logic        o_udp_gnt, o_tx_start, o_tx_kind, o_busy, o_arp_drop, o_timeout;
    logic [47:0] o_tx_dst_mac;
    logic [31:0] o_tx_dst_ip;
    logic [10:0] o_tx_len;
`ifdef ETH_TX_STATS_EN
    logic [15:0] o_arp_cnt, o_udp_cnt;
    logic [7:0]  o_to_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    eth_tx_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_self_mac    (SELF_MAC),
        .i_self_ip     (SELF_IP),
        .i_rx_pkt_type (i_rx_pkt_type),
        .i_rx_sha      (i_rx_sha),
        .i_rx_spa      (i_rx_spa),
        .i_rx_tpa      (i_rx_tpa),
        .i_udp_req     (i_udp_req),
        .i_udp_dst_mac (UDP_MAC),
        .i_udp_dst_ip  (UDP_IP),
        .i_udp_len     (UDP_LEN),
        .o_udp_gnt     (o_udp_gnt),
        .o_tx_start    (o_tx_start),
        .o_tx_kind     (o_tx_kind),
        .o_tx_dst_mac  (o_tx_dst_mac),
        .o_tx_dst_ip   (o_tx_dst_ip),
        .o_tx_len      (o_tx_len),
        .i_tx_done     (i_tx_done),
        .o_busy        (o_busy),
        .o_arp_drop    (o_arp_drop),
`ifdef ETH_TX_STATS_EN
        .o_arp_cnt     (o_arp_cnt),
        .o_udp_cnt     (o_udp_cnt),
        .o_to_cnt      (o_to_cnt),
`endif
        .o_timeout     (o_timeout)
    );

    typedef struct {
        int          n;
        logic [1:0]  typ;
        logic        match;
        logic [31:0] spa;
        logic        udp;
        logic        done;
        logic        start;
        logic        gnt;
        logic        kind;
        logic        busy;
        logic        drop;
        logic [31:0] ip;
        logic [10:0] len;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(int n, logic [1:0] typ, logic match, logic [31:0] spa, logic udp,
                                logic done, logic start, logic gnt, logic kind, logic busy,
                                logic drop, logic [31:0] ip, logic [10:0] len);
        vec_t v;
        v.n = n; v.typ = typ; v.match = match; v.spa = spa; v.udp = udp; v.done = done;
        v.start = start; v.gnt = gnt; v.kind = kind; v.busy = busy; v.drop = drop;
        v.ip = ip; v.len = len;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rx(input logic [1:0] typ, input logic match, input logic [31:0] spa);
        i_rx_pkt_type = typ;
        i_rx_tpa      = match ? SELF_IP : (SELF_IP ^ 32'h1);
        i_rx_spa      = spa;
        i_rx_sha      = {16'hA0A0, spa};
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".start"}, 64'(o_tx_start), 64'd0);
        chk({tag, ".gnt"}, 64'(o_udp_gnt), 64'd0);
        chk({tag, ".busy"}, 64'(o_busy), 64'd0);
        chk({tag, ".drop"}, 64'(o_arp_drop), 64'd0);
        chk({tag, ".timeout"}, 64'(o_timeout), 64'd0);
        chk({tag, ".kind"}, 64'(o_tx_kind), 64'd0);
        chk({tag, ".mac"}, 64'(o_tx_dst_mac), 64'd0);
        chk({tag, ".ip"}, 64'(o_tx_dst_ip), 64'd0);
        chk({tag, ".len"}, 64'(o_tx_len), 64'd0);
`ifdef ETH_TX_STATS_EN
        chk({tag, ".arp_cnt"}, 64'(o_arp_cnt), 64'd0);
        chk({tag, ".udp_cnt"}, 64'(o_udp_cnt), 64'd0);
        chk({tag, ".to_cnt"}, 64'(o_to_cnt), 64'd0);
`endif
    endtask

    initial begin
        int   starts, drops, g, sent, cnt, first, busy_cnt;
        logic kinds [7];
        logic exp_k [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic udp_off;

        vecs[0]  = mk(1,  ARP_REQ,  1, IP_A, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1,  NONE,     0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1,  NONE,     0, 0,    0, 0, 1, 0, 0, 1, 0, IP_A, 11'd28);
        vecs[3]  = mk(1,  ARP_REQ,  1, IP_B, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[4]  = mk(1,  ARP_REQ,  1, IP_C, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        vecs[5]  = mk(1,  NONE,     0, 0,    0, 1, 0, 0, 0, 1, 0, 0, 0);
        vecs[6]  = mk(12, NONE,     0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[7]  = mk(1,  NONE,     0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(1,  ARP_REQ,  1, IP_D, 0, 0, 1, 0, 0, 1, 0, IP_C, 11'd28);
        vecs[9]  = mk(1,  ARP_REQ,  0, IP_E, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        vecs[10] = mk(1,  ARP_RESP, 1, IP_E, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[11] = mk(11, NONE,     0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[12] = mk(1,  NONE,     0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(1,  NONE,     0, 0,    0, 0, 1, 0, 0, 1, 0, IP_D, 11'd28);
        vecs[14] = mk(1,  UDP,      1, IP_E, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        vecs[15] = mk(12, NONE,     0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[16] = mk(3,  NONE,     0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[17] = mk(1,  NONE,     0, 0,    1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[18] = mk(1,  NONE,     0, 0,    1, 0, 1, 1, 1, 1, 0, UDP_IP, UDP_LEN);
        vecs[19] = mk(1,  NONE,     0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[20] = mk(1,  NONE,     0, 0,    0, 1, 0, 0, 0, 1, 0, 0, 0);
        vecs[21] = mk(12, NONE,     0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[22] = mk(2,  NONE,     0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);

        #3;
        chk_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Cycle-by-cycle table: inputs driven after the edge, outputs checked at the falling edge
        for (int i = 0; i < 23; i++) begin
            for (int r = 0; r < vecs[i].n; r++) begin
                if (r > 0) step();
                drive_rx(vecs[i].typ, vecs[i].match, vecs[i].spa);
                i_udp_req = vecs[i].udp;
                i_tx_done = vecs[i].done;
                @(negedge clk);
                chk($sformatf("v%0d.%0d.start", i, r), 64'(o_tx_start), 64'(vecs[i].start));
                chk($sformatf("v%0d.%0d.gnt", i, r), 64'(o_udp_gnt), 64'(vecs[i].gnt));
                chk($sformatf("v%0d.%0d.busy", i, r), 64'(o_busy), 64'(vecs[i].busy));
                chk($sformatf("v%0d.%0d.drop", i, r), 64'(o_arp_drop), 64'(vecs[i].drop));
                chk($sformatf("v%0d.%0d.timeout", i, r), 64'(o_timeout), 64'd0);
                if (vecs[i].start) begin
                    chk($sformatf("v%0d.kind", i), 64'(o_tx_kind), 64'(vecs[i].kind));
                    chk($sformatf("v%0d.ip", i), 64'(o_tx_dst_ip), 64'(vecs[i].ip));
                    chk($sformatf("v%0d.len", i), 64'(o_tx_len), 64'(vecs[i].len));
                    chk($sformatf("v%0d.mac", i), 64'(o_tx_dst_mac),
                        vecs[i].kind ? 64'(UDP_MAC) : 64'({16'hA0A0, vecs[i].ip}));
                end
            end
            step();
        end
        drive_rx(NONE, 0, 0);
        i_udp_req = 1'b0;
        i_tx_done = 1'b0;

        // A request for somebody else's IP never produces a reply
        drive_rx(ARP_REQ, 0, IP_E);
        starts = 0;
        drops  = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            drive_rx(NONE, 0, 0);
            @(negedge clk);
            starts += int'(o_tx_start);
            drops  += int'(o_arp_drop);
        end
        chk("t2.starts", 64'(starts), 64'd0);
        chk("t2.drops", 64'(drops), 64'd0);

        // UDP held while ARP requests keep arriving: four ARPs, then UDP, then ARP again
        step();
        drive_rx(ARP_REQ, 1, IP_A);
        step();
        drive_rx(NONE, 0, 0);
        i_udp_req = 1'b1;
        g = 0; sent = 1; cnt = 0; drops = 0; udp_off = 1'b0;
        for (int c = 0; c < 600 && !(g == 7 && !o_busy); c++) begin
            step();
            drive_rx(NONE, 0, 0);
            i_tx_done = 1'b0;
            if (udp_off) i_udp_req = 1'b0;
            if (o_tx_start) begin
                kinds[g] = o_tx_kind;
                g++;
                cnt = 10;
                if (o_udp_gnt) udp_off = 1'b1;
                if (!o_tx_kind && sent < 6) begin
                    drive_rx(ARP_REQ, 1, IP_A + 32'(sent));
                    sent++;
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) i_tx_done = 1'b1;
            end
            @(negedge clk);
            drops += int'(o_arp_drop);
        end
        chk("t3.grants", 64'(g), 64'd7);
        for (int k = 0; k < 7; k++)
            if (k < g) chk($sformatf("t3.kind%0d", k), 64'(kinds[k]), 64'(exp_k[k]));
        chk("t3.drops", 64'(drops), 64'd0);
        chk("t3.idle", 64'(o_busy), 64'd0);
        step();
        drive_rx(NONE, 0, 0);
        i_tx_done = 1'b0;
        i_udp_req = 1'b0;

        // Framer never answers: timeout 2048 cycles after start, then a full IFG
        step();
        drive_rx(ARP_REQ, 1, IP_B);
        step();
        drive_rx(NONE, 0, 0);
        step();
        chk("t5.start", 64'(o_tx_start), 64'd1);
        first = 0;
        for (int k = 1; k <= 2100 && first == 0; k++) begin
            step();
            if (o_timeout) first = k;
        end
        chk("t5.timeout_cycle", 64'(first), 64'd2048);
        busy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            busy_cnt += int'(o_busy);
            if (k == 0) chk("t5.timeout_pulse", 64'(o_timeout), 64'd0);
        end
        chk("t5.ifg_len", 64'(busy_cnt), 64'd12);
        step();
        chk("t5.idle", 64'(o_busy), 64'd0);

        // Reset in the middle of a frame while another reply is pending
        drive_rx(ARP_REQ, 1, IP_C);
        step();
        drive_rx(NONE, 0, 0);
        step();
        step();
        drive_rx(ARP_REQ, 1, IP_D);
        step();
        drive_rx(NONE, 0, 0);
        chk("t6.busy_before", 64'(o_busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("t6");
        @(negedge clk);
        rst_n = 1'b1;
        starts = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            starts += int'(o_tx_start);
        end
        chk("t6.slot_empty", 64'(starts), 64'd0);
        chk("t6.idle", 64'(o_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
